// File: rtl/line_clipper.sv
// Sequential Cohen-Sutherland clipper for the 640x480 window: outcode units on the
// working endpoints, one boundary clip per iteration through a restoring divider.
module line_clipper #(
  parameter int COORD_W  = 16,
  parameter int XMIN     = 0,
  parameter int XMAX     = 640,
  parameter int YMIN     = 0,
  parameter int YMAX     = 480,
  parameter int MAX_ITER = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] in_x0,
  input  logic signed [COORD_W-1:0] in_y0,
  input  logic signed [COORD_W-1:0] in_x1,
  input  logic signed [COORD_W-1:0] in_y1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_accept,
  output logic signed [COORD_W-1:0] out_x0,
  output logic signed [COORD_W-1:0] out_y0,
  output logic signed [COORD_W-1:0] out_x1,
  output logic signed [COORD_W-1:0] out_y1
);

  localparam int W1         = COORD_W + 1;
  localparam int PW         = 2 * COORD_W + 2;
  localparam int DIV_CYCLES = PW;
  localparam int CW         = $clog2(DIV_CYCLES);
  localparam int IW         = $clog2(MAX_ITER + 1);

  localparam logic signed [COORD_W-1:0] XMIN_C = COORD_W'(XMIN);
  localparam logic signed [COORD_W-1:0] XMAX_C = COORD_W'(XMAX);
  localparam logic signed [COORD_W-1:0] YMIN_C = COORD_W'(YMIN);
  localparam logic signed [COORD_W-1:0] YMAX_C = COORD_W'(YMAX);

  typedef enum logic [2:0] {IDLE, EVAL, SETUP, DIV, UPDATE, OUT} state_t;

  state_t                      state_reg, state_next;
  logic signed [COORD_W-1:0]   wx_reg [2];
  logic signed [COORD_W-1:0]   wy_reg [2];
  logic [3:0]                  oc [2];
  logic [IW-1:0]               iter_reg;
  logic                        acc_reg, sel_reg, clip_y_reg, neg_reg;
  logic signed [COORD_W-1:0]   bound_reg;
  logic [PW-1:0]               quo_reg;
  logic [W1-1:0]               rem_reg, dmag_reg;
  logic [CW-1:0]               cnt_reg;
  logic                        out_valid_reg, out_accept_reg;
  logic signed [COORD_W-1:0]   out_x0_reg, out_y0_reg, out_x1_reg, out_y1_reg;

  // Outcode bits are {TOP, BOTTOM, RIGHT, LEFT}; window edges count as inside.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_outcode
      assign oc[gi] = {wy_reg[gi] > YMAX_C, wy_reg[gi] < YMIN_C,
                       wx_reg[gi] > XMAX_C, wx_reg[gi] < XMIN_C};
    end
  endgenerate

  logic                      sel_c, clip_y_c;
  logic [3:0]                code_c;
  logic signed [COORD_W-1:0] bound_c;
  logic signed [W1-1:0]      dx_c, dy_c, mul_a_c, ofs_c, div_c;
  logic signed [PW-1:0]      num_c;
  logic [PW-1:0]             num_mag_c;
  logic [W1-1:0]             div_mag_c;

  // Endpoint/boundary selection and divide operands; endpoint 0 is always the reference.
  always_comb begin
    sel_c    = (oc[0] == 4'd0);
    code_c   = sel_c ? oc[1] : oc[0];
    clip_y_c = 1'b1;
    bound_c  = YMAX_C;
    if (code_c[3]) begin
      bound_c = YMAX_C;
    end else if (code_c[2]) begin
      bound_c = YMIN_C;
    end else if (code_c[1]) begin
      clip_y_c = 1'b0;
      bound_c  = XMAX_C;
    end else begin
      clip_y_c = 1'b0;
      bound_c  = XMIN_C;
    end
    dx_c = W1'(wx_reg[1]) - W1'(wx_reg[0]);
    dy_c = W1'(wy_reg[1]) - W1'(wy_reg[0]);
    if (clip_y_c) begin
      mul_a_c = dx_c;
      ofs_c   = W1'(bound_c) - W1'(wy_reg[0]);
      div_c   = dy_c;
    end else begin
      mul_a_c = dy_c;
      ofs_c   = W1'(bound_c) - W1'(wx_reg[0]);
      div_c   = dx_c;
    end
    num_c     = PW'(mul_a_c) * PW'(ofs_c);
    num_mag_c = num_c[PW-1] ? -num_c : num_c;
    div_mag_c = div_c[W1-1] ? -div_c : div_c;
  end

  logic [W1:0]               rem_shift_c;
  logic                      rem_ge_c;
  logic signed [COORD_W-1:0] q_c, other_c;

  always_comb begin
    rem_shift_c = {rem_reg, quo_reg[PW-1]};
    rem_ge_c    = (rem_shift_c >= {1'b0, dmag_reg});
    q_c         = neg_reg ? -quo_reg[COORD_W-1:0] : quo_reg[COORD_W-1:0];
    other_c     = (clip_y_reg ? wx_reg[0] : wy_reg[0]) + q_c;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (in_valid) state_next = EVAL;
      EVAL: begin
        if ((oc[0] == 4'd0 && oc[1] == 4'd0) || ((oc[0] & oc[1]) != 4'd0) ||
            iter_reg == IW'(MAX_ITER))
          state_next = OUT;
        else
          state_next = SETUP;
      end
      SETUP:  state_next = DIV;
      DIV:    if (cnt_reg == CW'(DIV_CYCLES - 1)) state_next = UPDATE;
      UPDATE: state_next = EVAL;
      OUT:    if (out_valid_reg && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 2; i++) begin
        wx_reg[i] <= '0;
        wy_reg[i] <= '0;
      end
      iter_reg       <= '0;
      acc_reg        <= 1'b0;
      sel_reg        <= 1'b0;
      clip_y_reg     <= 1'b0;
      neg_reg        <= 1'b0;
      bound_reg      <= '0;
      quo_reg        <= '0;
      rem_reg        <= '0;
      dmag_reg       <= '0;
      cnt_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_accept_reg <= 1'b0;
      out_x0_reg     <= '0;
      out_y0_reg     <= '0;
      out_x1_reg     <= '0;
      out_y1_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            wx_reg[0] <= in_x0;
            wy_reg[0] <= in_y0;
            wx_reg[1] <= in_x1;
            wy_reg[1] <= in_y1;
            iter_reg  <= '0;
          end
        end
        EVAL: acc_reg <= (oc[0] == 4'd0) && (oc[1] == 4'd0);
        SETUP: begin
          sel_reg    <= sel_c;
          clip_y_reg <= clip_y_c;
          bound_reg  <= bound_c;
          neg_reg    <= num_c[PW-1] ^ div_c[W1-1];
          quo_reg    <= num_mag_c;
          rem_reg    <= '0;
          dmag_reg   <= div_mag_c;
          cnt_reg    <= '0;
        end
        DIV: begin
          quo_reg <= {quo_reg[PW-2:0], rem_ge_c};
          rem_reg <= rem_ge_c ? W1'(rem_shift_c - {1'b0, dmag_reg}) : rem_shift_c[W1-1:0];
          cnt_reg <= cnt_reg + 1'b1;
        end
        UPDATE: begin
          if (clip_y_reg) begin
            wy_reg[sel_reg] <= bound_reg;
            wx_reg[sel_reg] <= other_c;
          end else begin
            wx_reg[sel_reg] <= bound_reg;
            wy_reg[sel_reg] <= other_c;
          end
          iter_reg <= iter_reg + 1'b1;
        end
        OUT: begin
          // First OUT cycle captures the result; it then holds until the handshake.
          if (!out_valid_reg) begin
            out_valid_reg  <= 1'b1;
            out_accept_reg <= acc_reg;
            out_x0_reg     <= acc_reg ? wx_reg[0] : '0;
            out_y0_reg     <= acc_reg ? wy_reg[0] : '0;
            out_x1_reg     <= acc_reg ? wx_reg[1] : '0;
            out_y1_reg     <= acc_reg ? wy_reg[1] : '0;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = out_valid_reg;
  assign out_accept = out_accept_reg;
  assign out_x0     = out_x0_reg;
  assign out_y0     = out_y0_reg;
  assign out_x1     = out_x1_reg;
  assign out_y1     = out_y1_reg;

endmodule

// File: tb/tb_line_clipper.sv
// Bench for line_clipper: vector table with latencies, scoreboard queue checked on each
// output handshake, plus reset, mid-divide reset and backpressure sequences.
module tb_line_clipper;

  logic               tb_clk = 1'b0;
  logic               n_rst;
  logic               in_valid, in_ready;
  logic signed [15:0] in_x0, in_y0, in_x1, in_y1;
  logic               out_valid, out_ready, out_accept;
  logic signed [15:0] out_x0, out_y0, out_x1, out_y1;

  always #5 tb_clk = ~tb_clk;

  line_clipper dut (
    .clk(tb_clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x0(in_x0), .in_y0(in_y0), .in_x1(in_x1), .in_y1(in_y1),
    .out_valid(out_valid), .out_ready(out_ready), .out_accept(out_accept),
    .out_x0(out_x0), .out_y0(out_y0), .out_x1(out_x1), .out_y1(out_y1)
  );

  typedef struct {
    int x0, y0, x1, y1;
    int acc;
    int ex0, ey0, ex1, ey1;
    int lat;
  } vec_t;

  typedef struct {
    int acc;
    int x0, y0, x1, y1;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[11];

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  // Scoreboard: compare at the negedge before each output handshake edge.
  always @(negedge tb_clk) begin
    if (n_rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_accept", 32'(out_accept), mon_e.acc);
        chk("out_x0", 32'(out_x0), mon_e.x0);
        chk("out_y0", 32'(out_y0), mon_e.y0);
        chk("out_x1", 32'(out_x1), mon_e.x1);
        chk("out_y1", 32'(out_y1), mon_e.y1);
        $display("result: acc=%0d (%0d,%0d)-(%0d,%0d)", out_accept, out_x0, out_y0,
                 out_x1, out_y1);
      end
    end
  end

  task automatic drive(input vec_t v);
    in_x0    = 16'(v.x0);
    in_y0    = 16'(v.y0);
    in_x1    = 16'(v.x1);
    in_y1    = 16'(v.y1);
    in_valid = 1'b1;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.acc = v.acc;
    e.x0 = v.ex0; e.y0 = v.ey0; e.x1 = v.ex1; e.y1 = v.ey1;
    sb_q.push_back(e);
  endtask

  // Waits for out_valid after the handshake edge; returns -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge tb_clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge tb_clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    drive(v);
    push_exp(v);
    @(posedge tb_clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    chk("latency", lat, v.lat);
    if (lat < 0) sb_q.delete(sb_q.size() - 1);
    @(posedge tb_clk);
    #1;
    chk("out_valid_drop", 32'(out_valid), 0);
    chk("in_ready_back", 32'(in_ready), 1);
    $display("vec %0d: (%0d,%0d)-(%0d,%0d) latency=%0d", idx, v.x0, v.y0, v.x1, v.y1, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    vecs[0]  = '{100, 100, 300, 400, 1, 100, 100, 300, 400, 2};
    vecs[1]  = '{640, 480, 0, 0, 1, 640, 480, 0, 0, 2};
    vecs[2]  = '{-100, -100, -50, 300, 0, 0, 0, 0, 0, 2};
    vecs[3]  = '{10, 500, 600, 700, 0, 0, 0, 0, 0, 2};
    vecs[4]  = '{-100, 300, 300, 300, 1, 0, 300, 300, 300, 39};
    vecs[5]  = '{320, 240, 800, 240, 1, 320, 240, 640, 240, 39};
    vecs[6]  = '{100, 100, 200, 600, 1, 100, 100, 176, 480, 39};
    vecs[7]  = '{500, 100, 99, 600, 1, 500, 100, 196, 480, 39};
    vecs[8]  = '{-100, 400, 100, 600, 0, 0, 0, 0, 0, 39};
    vecs[9]  = '{-100, -100, 740, 580, 1, 23, 0, 616, 480, 76};
    vecs[10] = '{600, 100, 700, -100, 1, 600, 100, 640, 20, 76};

    // Reset with in_valid held high.
    n_rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_x0 = 16'sd5; in_y0 = 16'sd5; in_x1 = 16'sd6; in_y1 = 16'sd6;
    repeat (3) @(posedge tb_clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_accept", 32'(out_accept), 0);
    chk("rst_out_x0", 32'(out_x0), 0);
    chk("rst_out_y0", 32'(out_y0), 0);
    chk("rst_out_x1", 32'(out_x1), 0);
    chk("rst_out_y1", 32'(out_y1), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
    @(negedge tb_clk) n_rst = 1'b1;
    @(posedge tb_clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Backpressure: result held 20 clocks while a new in_valid is offered.
    out_ready = 1'b0;
    @(negedge tb_clk);
    drive(vecs[0]);
    push_exp(vecs[0]);
    @(posedge tb_clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    chk("bp_latency", lat, 2);
    for (int i = 0; i < 20; i++) begin
      @(posedge tb_clk);
      #1;
      if (i == 3) begin
        in_x0 = 16'sd1; in_y0 = 16'sd2; in_x1 = 16'sd3; in_y1 = 16'sd4;
        in_valid = 1'b1;
      end
      if (i == 9) in_valid = 1'b0;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold", {out_accept, out_x0[9:0], out_y0[9:0], out_x1[10:0]},
          {1'b1, 10'd100, 10'd100, 11'd300});
      chk("bp_hold_y1", 32'(out_y1), vecs[0].ey1);
    end
    out_ready = 1'b1;
    @(posedge tb_clk);
    #1;
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_release_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (10) begin
      @(posedge tb_clk);
      #1;
      if (out_valid) seen++;
    end
    chk("bp_ignored_input", seen, 0);
    $display("backpressure: hold 20 clocks, released");

    // Reset asserted while the divider is running.
    @(negedge tb_clk);
    drive(vecs[4]);
    @(posedge tb_clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge tb_clk);
    @(negedge tb_clk) n_rst = 1'b0;
    #1;
    chk("div_rst_out_valid", 32'(out_valid), 0);
    chk("div_rst_in_ready", 32'(in_ready), 1);
    @(negedge tb_clk) n_rst = 1'b1;
    seen = 0;
    repeat (60) begin
      @(posedge tb_clk);
      #1;
      if (out_valid) seen++;
    end
    chk("div_rst_no_result", seen, 0);
    $display("reset mid-divide: segment dropped");
    run_vec(vecs[9], 9);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
